demux_1_4_buf: RTL
==================

# demux_1_4_buf

Registered 1-to-4 demultiplexer with per-lane buffering. It does the opposite job to the 4:1 datapath multiplexers: it takes one N-bit stream and steers each word to one of four destination lanes, chosen by a 2-bit select. Each lane has its own valid/ready handshake and a 2-entry FIFO, so a stalled destination blocks only the words addressed to it. It sits between a single producer (e.g. the writeback/store path) and up to four consumers (register file port, memory-mapped peripherals, debug sink).

## Interface
- N, default 32: data width in bits.
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N  word offered by the producer.
- in_sel  input  2  destination lane: 0=A, 1=B, 2=C, 3=D.
- in_valid  input  1  producer has a word on in_data/in_sel.
- in_ready  output  1  block will accept the word this cycle.
- out_data_A/B/C/D  output  N each  head word of the lane.
- out_valid_A/B/C/D  output  1 each  the lane head word is valid.
- out_ready_A/B/C/D  input  1 each  the consumer takes the head word this cycle.

## Operation
- Each lane has a 2-entry FIFO: two N-bit entries, a 1-bit write pointer, a 1-bit read pointer and a 2-bit count (0..2). The pointers wrap 1→0.
- Input accept: the word is accepted when in_valid && in_ready at a clk edge, and is written to lane in_sel.
- in_ready = !rst && (count[in_sel] != 2).
  - in_ready depends combinationally on in_sel only. It does not depend on any out_ready.
  - A full lane does not accept a word in the same cycle it pops one. There is no ready pass-through.
- Output: out_valid_X = (count_X != 0). out_data_X = entry[rd_ptr_X].
- A pop occurs when out_valid_X && out_ready_X. After a pop, rd_ptr_X toggles.
- Push and pop on the same lane in the same cycle: count is unchanged, both pointers advance, and data order is preserved.
- Pushes to one lane and pops from other lanes in the same cycle are independent.
- Lanes never reorder words. Words sent to different lanes carry no ordering relation.
- out_valid_X never deasserts without a pop. out_data_X stays stable while out_valid_X && !out_ready_X.
- out_ready_X with count_X = 0 is ignored. No state changes.
- in_sel is a don't-care when in_valid = 0. in_ready still reflects the lane it selects.

## Timing
- Reset, synchronous on the clk edge with rst=1:
  - all counts and pointers go to 0;
  - all out_valid go to 0;
  - all out_data go to 0, because the storage entries are cleared;
  - in_ready is 0 while rst is high.
- Reset asserted mid-operation discards all buffered words. A handshake that completes in the reset cycle is lost.
- Latency without bypass: a word accepted at edge k is visible on out_valid_X/out_data_X after edge k, so it can be consumed at edge k+1.
- Throughput: one word per cycle sustained into a lane whose consumer holds out_ready high.
- Back-pressure: with the consumer stalled, a lane absorbs exactly 2 words. in_ready then drops for that lane only.

## Configuration
- DEMUX_BYPASS_EN:
  - When defined, and lane X is empty (count_X = 0), the lane drives out_valid_X = in_valid && (in_sel == X) and out_data_X = in_data combinationally.
  - If out_ready_X is also high, the word is consumed with 0-cycle latency and is not written to the FIFO. Count stays 0.
  - If out_ready_X is low, the word is stored as normal.
  - The reset values apply unchanged, because in_ready = 0 blocks bypass during reset.
- When not defined, outputs are driven purely from FIFO registers and latency is always 1 cycle.

## Test plan
- Reset release with all four lanes idle: out_valid_A..D = 0, out_data_A..D = 0, and in_ready = 1 on the first cycle after rst deasserts.
- Route sequence, all out_ready high:
  - send 4526→sel 0, 5659→sel 1, 745→sel 2, 2156→sel 3 on consecutive cycles;
  - each value appears once on lanes A, B, C, D respectively, one cycle after acceptance (0 cycles with DEMUX_BYPASS_EN);
  - no other lane asserts valid.
- Back-pressure on lane C:
  - hold out_ready_C = 0 and send 78515, 4548, 1558, all with sel=2;
  - the first two are accepted, then in_ready drops for sel=2 while the third is held;
  - switching in_sel to 0 restores in_ready = 1.
- Full lane with simultaneous pop:
  - lane B holds 1568, 5659; drive out_ready_B = 1 with in_valid and sel=1;
  - in_ready stays 0 in that cycle and 1568 pops;
  - the next cycle accepts the new word, and order is 5659 then the new word.
- Push and pop on the same lane with count=1: count stays 1, output order is preserved, and the pointers wrap correctly over 6 consecutive transfers.
- Reset mid-traffic: with lanes A and D holding data, asserting rst for one cycle clears all valids, zeroes out_data, and nothing reappears afterwards.

Source files
------------

// File: rtl/demux_1_4_buf.sv
// Registered 1-to-4 demultiplexer: one input stream steered by in_sel into four
// lanes, each with a 2-entry FIFO and its own valid/ready handshake. Optional
// zero-latency bypass into an empty lane is enabled by defining DEMUX_BYPASS_EN.
module demux_1_4_buf #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in_data,
   input  logic [1:0]   in_sel,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] out_data_A,
   output logic [N-1:0] out_data_B,
   output logic [N-1:0] out_data_C,
   output logic [N-1:0] out_data_D,
   output logic         out_valid_A,
   output logic         out_valid_B,
   output logic         out_valid_C,
   output logic         out_valid_D,
   input  logic         out_ready_A,
   input  logic         out_ready_B,
   input  logic         out_ready_C,
   input  logic         out_ready_D
);

   logic [N-1:0] mem [4][2];
   logic [3:0]   wr_ptr;
   logic [3:0]   rd_ptr;
   logic [1:0]   count [4];

   logic [3:0]   lane_ready;
   logic [3:0]   lane_valid;
   logic [3:0]   push;
   logic [3:0]   store;
   logic [3:0]   fifo_pop;
   logic [N-1:0] lane_data [4];

   assign lane_ready = {out_ready_D, out_ready_C, out_ready_B, out_ready_A};

   // Readiness looks only at the selected lane's fill level, never at a consumer.
   assign in_ready = !rst && (count[in_sel] != 2'd2);

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         push[i]       = in_valid && in_ready && (in_sel == 2'(i));
         fifo_pop[i]   = (count[i] != 2'd0) && lane_ready[i];
         store[i]      = push[i];
         lane_valid[i] = (count[i] != 2'd0);
         lane_data[i]  = mem[i][rd_ptr[i]];
`ifdef DEMUX_BYPASS_EN
         // An empty lane presents the incoming word directly; it is only stored
         // when the consumer does not take it in the same cycle.
         if ((count[i] == 2'd0) && push[i]) begin
            lane_valid[i] = 1'b1;
            lane_data[i]  = in_data;
            store[i]      = !lane_ready[i];
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < 4; i++) begin
            count[i]  <= 2'd0;
            mem[i][0] <= '0;
            mem[i][1] <= '0;
         end
      end else begin
         wr_ptr <= wr_ptr ^ store;
         rd_ptr <= rd_ptr ^ fifo_pop;
         for (int i = 0; i < 4; i++) begin
            if (store[i])
               mem[i][wr_ptr[i]] <= in_data;
            count[i] <= count[i] + {1'b0, store[i]} - {1'b0, fifo_pop[i]};
         end
      end
   end

   assign out_data_A  = lane_data[0];
   assign out_data_B  = lane_data[1];
   assign out_data_C  = lane_data[2];
   assign out_data_D  = lane_data[3];
   assign out_valid_A = lane_valid[0];
   assign out_valid_B = lane_valid[1];
   assign out_valid_C = lane_valid[2];
   assign out_valid_D = lane_valid[3];

endmodule
